// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: requester handshake and register-file write-port bundle
// master: writeback sources / bench (drive req_*, wr_stall; observe grant and write port)
// slave : regfile_wr_arbiter (drives req_ready and the registered wr_* port)
//   req_valid[NUM_REQ]       per-requester write request
//   req_addr[NUM_REQ*5]      packed addresses, requester i at [5i+4:5i]
//   req_data[NUM_REQ*DATA_W] packed data, requester i at [DATA_W*i +: DATA_W]
//   req_ready[NUM_REQ]       combinational grant, zero- or one-hot
//   wr_stall                 register file busy, blocks all grants
//   wr_en[32]                registered one-hot write-enable
//   wr_addr[5], wr_data, wr_src[3]  registered address/data/source of last transfer
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*5-1:0]      req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_stall;
  logic [31:0]               wr_en;
  logic [4:0]                wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [2:0]                wr_src;
  modport master (
    output req_valid, req_addr, req_data, wr_stall,
    input  req_ready, wr_en, wr_addr, wr_data, wr_src
  );
  modport slave (
    input  req_valid, req_addr, req_data, wr_stall,
    output req_ready, wr_en, wr_addr, wr_data, wr_src
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin scheduler for the single register-file write port
// Ports: i_clk (rising edge), i_rst_n (async active-low), bus (regfile_wr_arbiter_if.slave)
// Option: define REGWR_ARB_ZERO_SQUASH_EN to suppress wr_en for writes to address 0
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input logic                i_clk,
  input logic                i_rst_n,
  regfile_wr_arbiter_if.slave bus
);
  logic [2:0]         r_ptr;
  logic [2:0]         r_wr_src;
  logic [31:0]        r_wr_en;
  logic [4:0]         r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic               w_found;
  logic               w_xfer;
  logic [2:0]         w_idx;
  logic [3:0]         w_pos;
  logic [3:0]         w_nxt;
  logic [NUM_REQ-1:0] w_shift;
  logic [4:0]         w_addr;
  logic [DATA_W-1:0]  w_data;
  logic [31:0]        w_dec;
  // Walk requesters from r_ptr upward, wrapping modulo NUM_REQ; first valid wins
  always_comb begin
    w_found = 1'b0;
    w_idx   = 3'd0;
    w_pos   = 4'd0;
    w_shift = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos   = {1'b0, r_ptr} + 4'(k);
      w_pos   = (w_pos >= 4'(NUM_REQ)) ? w_pos - 4'(NUM_REQ) : w_pos;
      w_shift = bus.req_valid >> w_pos;
      if (!w_found && w_shift[0]) begin
        w_found = 1'b1;
        w_idx   = w_pos[2:0];
      end
    end
  end
  // Grant is withheld during stall and while reset is asserted
  assign w_xfer        = w_found & ~bus.wr_stall & i_rst_n;
  assign bus.req_ready = w_xfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign w_addr        = bus.req_addr[5*w_idx +: 5];
  assign w_data        = bus.req_data[DATA_W*w_idx +: DATA_W];
  assign w_nxt         = {1'b0, w_idx} + 4'd1;
`ifdef REGWR_ARB_ZERO_SQUASH_EN
  assign w_dec = (w_addr == 5'd0) ? 32'd0 : 32'd1 << w_addr;
`else
  assign w_dec = 32'd1 << w_addr;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr     <= 3'd0;
      r_wr_en   <= 32'd0;
      r_wr_addr <= 5'd0;
      r_wr_data <= '0;
      r_wr_src  <= 3'd0;
    end else begin
      r_wr_en <= w_xfer ? w_dec : 32'd0;
      if (w_xfer) begin
        r_ptr     <= (w_nxt == 4'(NUM_REQ)) ? 3'd0 : w_nxt[2:0];
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
        r_wr_src  <= w_idx;
      end
    end
  end
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.wr_src  = r_wr_src;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed self-checking bench for regfile_wr_arbiter
// Drives and samples on the falling edge; one linear stimulus sequence.
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  regfile_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();
  regfile_wr_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n         = 1'b0;
    bus.wr_stall  = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    bus.req_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_wr_en", bus.wr_en, 32'h0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    chk("rst_wr_src", 32'(bus.wr_src), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rr_ready0", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk("rr_en0", bus.wr_en, 32'h2);
    chk("rr_src0", 32'(bus.wr_src), 32'h0);
    chk("rr_data0", bus.wr_data, 32'h1111_1111);
    chk("rr_ready1", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    chk("rr_en1", bus.wr_en, 32'h4);
    chk("rr_src1", 32'(bus.wr_src), 32'h1);
    chk("rr_ready2", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    chk("rr_en2", bus.wr_en, 32'h8);
    chk("rr_src2", 32'(bus.wr_src), 32'h2);
    chk("rr_ready3", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    chk("rr_en3", bus.wr_en, 32'h10);
    chk("rr_src3", 32'(bus.wr_src), 32'h3);
    chk("rr_data3", bus.wr_data, 32'h4444_4444);
    chk("rr_ready_wrap", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk("rr_en4", bus.wr_en, 32'h2);
    chk("rr_src4", 32'(bus.wr_src), 32'h0);
    chk("st_ready_pre", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    chk("st_en_req1", bus.wr_en, 32'h4);
    chk("st_src_req1", 32'(bus.wr_src), 32'h1);
    bus.wr_stall = 1'b1;
    #1;
    chk("st_ready_a", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    chk("st_en_a", bus.wr_en, 32'h0);
    chk("st_addr_hold_a", 32'(bus.wr_addr), 32'h2);
    chk("st_src_hold_a", 32'(bus.wr_src), 32'h1);
    chk("st_ready_b", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    chk("st_en_b", bus.wr_en, 32'h0);
    chk("st_data_hold_b", bus.wr_data, 32'h2222_2222);
    bus.wr_stall = 1'b0;
    #1;
    chk("st_release_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    chk("st_release_en", bus.wr_en, 32'h8);
    chk("st_release_src", 32'(bus.wr_src), 32'h2);
    bus.req_valid     = 4'h1;
    bus.req_addr[4:0] = 5'd5;
    bus.req_data[31:0] = 32'hDEAD_BEEF;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk("single_en", bus.wr_en, 32'h20);
    chk("single_addr", 32'(bus.wr_addr), 32'h5);
    chk("single_data", bus.wr_data, 32'hDEAD_BEEF);
    chk("single_src", 32'(bus.wr_src), 32'h0);
    bus.req_valid = 4'h0;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    chk("single_en_off", bus.wr_en, 32'h0);
    chk("single_addr_hold", 32'(bus.wr_addr), 32'h5);
    bus.req_valid     = 4'h2;
    bus.req_addr[9:5] = 5'd31;
    #1;
    chk("a31_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    chk("a31_en", bus.wr_en, 32'h8000_0000);
    chk("a31_addr", 32'(bus.wr_addr), 32'd31);
    chk("a31_src", 32'(bus.wr_src), 32'h1);
    bus.req_valid       = 4'h4;
    bus.req_addr[14:10] = 5'd0;
    bus.req_data[95:64] = 32'hCAFE_0000;
    #1;
    chk("a0_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
`ifdef REGWR_ARB_ZERO_SQUASH_EN
    chk("a0_en", bus.wr_en, 32'h0);
`else
    chk("a0_en", bus.wr_en, 32'h1);
`endif
    chk("a0_addr", 32'(bus.wr_addr), 32'h0);
    chk("a0_data", bus.wr_data, 32'hCAFE_0000);
    chk("a0_src", 32'(bus.wr_src), 32'h2);
    bus.req_valid = 4'hF;
    #1;
    chk("a0_ptr_adv", 32'(bus.req_ready), 32'h8);
    @(posedge clk);
    #1;
    chk("mid_en_pre", bus.wr_en, 32'h10);
    chk("mid_src_pre", 32'(bus.wr_src), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("mid_en_clr", bus.wr_en, 32'h0);
    chk("mid_addr_clr", 32'(bus.wr_addr), 32'h0);
    chk("mid_data_clr", bus.wr_data, 32'h0);
    chk("mid_src_clr", 32'(bus.wr_src), 32'h0);
    chk("mid_ready_clr", 32'(bus.req_ready), 32'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ptr_restart", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 4'h0;
    @(negedge clk);
    chk("post_rst_en", bus.wr_en, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin write-port scheduler for the 32-entry register file. It shares the single register-file write port among up to `NUM_REQ` requesters, such as the ALU writeback, load return and link-register writer. It drives the port through a 5→32 one-hot address decode, so that exactly one register write-enable is asserted per granted transfer. The block sits between the writeback sources and the register file, and owns the decode of the write address.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `DATA_W`, default 32: write data width.
- `CLK` input, 1 bit: system clock; all state is updated on the rising edge.
- `RST` input, 1 bit: reset, asynchronous, active-low.
- `req_valid` input, `NUM_REQ` bits: per-requester write request.
- `req_addr` input, `NUM_REQ*5` bits: packed register addresses; requester i occupies `[5i+4:5i]`.
- `req_data` input, `NUM_REQ*DATA_W` bits: packed write data; requester i occupies `[DATA_W*i+DATA_W-1:DATA_W*i]`.
- `req_ready` output, `NUM_REQ` bits: grant; combinational; zero-hot or one-hot.
- `wr_stall` input, 1 bit: register file busy; blocks all grants.
- `wr_en` output, 32 bits: registered one-hot register write-enable.
- `wr_addr` output, 5 bits: registered address of the last transfer.
- `wr_data` output, `DATA_W` bits: registered data of the last transfer.
- `wr_src` output, 3 bits: registered index of the last granted requester.

## Operation
- **Round-robin pointer.** A 3-bit `ptr` holds the highest-priority requester index.
  - Search order is `ptr`, `ptr+1`, …, wrapping modulo `NUM_REQ`.
  - The first requester in that order with `req_valid=1` receives `req_ready=1`.
- **Transfer.** A transfer occurs when `req_valid[i] & req_ready[i]`.
  - On the edge that completes the transfer, `ptr` becomes `(i+1) mod NUM_REQ`.
  - With no transfer, `ptr` is unchanged.
- **Stall.** `wr_stall=1` forces `req_ready` to zero and leaves `ptr` unchanged.
- **Requester rules.** A requester holds `req_valid`, `req_addr` and `req_data` stable until it sees `req_ready`. The arbiter does not sample unhandshaked data.
- **Output register.**
  - On a transfer edge, it loads `wr_en = 32'b1 << req_addr[i]`, `wr_addr = req_addr[i]`, `wr_data = req_data[i]` and `wr_src = i`.
  - On any other edge, `wr_en` is 0, and `wr_addr`, `wr_data` and `wr_src` hold their values.
- **Outputs at most once per transfer.** `wr_en` is never asserted for two consecutive cycles from a single transfer. Back-to-back transfers produce back-to-back single-cycle pulses.
- **Decode width.** The decode is a full 5-bit decode, so address 31 yields `32'h8000_0000`. Address bits above 4 do not exist.
- **Asynchronous reset.** Asserting `RST` low at any time, including mid-stream, clears state immediately:
  - `ptr = 0`, `wr_en = 0`, `wr_addr = 0`, `wr_data = 0`, `wr_src = 0`.
  - `req_ready` is forced to 0 while `RST` is low.
  - A transfer in flight at reset is lost; the requester must re-request.

## Timing
- `req_ready` is valid in the same cycle as `req_valid`, after combinational settling.
- Latency is 1 cycle: a transfer at edge N produces `wr_en`, `wr_addr` and `wr_data` in cycle N..N+1.
- Throughput is one transfer per cycle.
- Fairness: any continuously valid requester is granted within `NUM_REQ` cycles of non-stalled operation.
- When `req_valid` changes and `wr_stall` is released in the same cycle, the grant is computed from current-cycle values.

## Configuration
- `REGWR_ARB_ZERO_SQUASH_EN` defined:
  - A transfer with address 0 completes its handshake normally, and updates `ptr`, `wr_addr`, `wr_data` and `wr_src`.
  - `wr_en` stays `32'h0`, because $zero is never written.
- `REGWR_ARB_ZERO_SQUASH_EN` undefined:
  - Address 0 decodes like any other address, giving `wr_en = 32'h0000_0001`.
  - The register file is then responsible for ignoring writes to $zero.

## Test plan
- **Reset.** Drive `RST` low with all requesters valid.
  - Required: `req_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `wr_src=0`.
  - Release `RST`: the first grant goes to requester 0.
- **Single request.** Requester 0 only, addr 5, data `32'hDEADBEEF`.
  - Required: `req_ready=4'b0001` in the same cycle.
  - Next cycle: `wr_en=32'h20`, `wr_addr=5`, `wr_data=DEADBEEF`, `wr_src=0`.
  - The cycle after that: `wr_en=0`.
- **Round-robin.** All 4 requesters held valid with addresses 1, 2, 3, 4.
  - Required grant order: 0, 1, 2, 3, 0.
  - Required `wr_en` sequence: `32'h2`, `32'h4`, `32'h8`, `32'h10`, `32'h2` on consecutive cycles.
- **Stall mid-stream.** Assert `wr_stall` for 2 cycles after the grant to requester 1.
  - Required: `req_ready=0` and `wr_en=0` during the stall, with outputs holding.
  - On release: requester 2 is granted next.
- **Boundary addresses.** Addr 31 yields `wr_en=32'h8000_0000`.
  - Addr 0 yields `wr_en=0` with the macro defined.
  - Addr 0 yields `wr_en=32'h1` without the macro.
  - In both builds, `wr_addr=0` and `ptr` advances.
- **Reset mid-operation.** Pulse `RST` low between the edge and the output cycle of a transfer.
  - Required: `wr_en` clears immediately.
  - After reset: `ptr` restarts at 0.
